pc_sequencer: RTL

Multi-cycle fetch/decode sequencer that owns the architectural PC and acts as the initiator for the jump unit's enable/done handshake. It requests instructions, decodes jump-class instructions (`j`, `jal`, `jr`), drives the jump unit's request fields and holds `unit_en` until `unit_done`. It then commits the returned target PC. Non-jump instructions advance PC by one word without involving the jump unit.

---
 rtl/pc_seq_pkg.sv | 26 ++
 rtl/pc_sequencer_if.sv | 22 ++
 rtl/pc_sequencer_jump_decoder.sv | 28 ++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and encodings for the PC sequencer and its jump decoder.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_ERROR
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    localparam logic [3:0] PATH_SEQ = 4'd0;
    localparam logic [3:0] PATH_J   = 4'd5;
    localparam logic [3:0] PATH_JAL = 4'd6;
    localparam logic [3:0] PATH_JR  = 4'd8;

    // Register written by link_we (the return-address register).
    localparam logic [4:0] LINK_REG = 5'd31;

endpackage

// File: rtl/pc_sequencer_if.sv
// Enable/done handshake between the PC sequencer (master) and the jump unit (slave).
interface pc_sequencer_if;

    logic        unit_en;
    logic        jump;
    logic [3:0]  path_index;
    logic [25:0] addr;
    logic [31:0] reg_addr;
    logic        unit_done;
    logic [31:0] next_pc;

    modport master (
        output unit_en, jump, path_index, addr, reg_addr,
        input  unit_done, next_pc
    );

    modport slave (
        input  unit_en, jump, path_index, addr, reg_addr,
        output unit_done, next_pc
    );

endinterface

// File: rtl/pc_sequencer_jump_decoder.sv
// Combinational classifier for jump-class instructions (j, jal, jr).
module jump_decoder
    import pc_seq_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  path_index,
    output logic        jump,
    output logic [25:0] addr,
    output logic [4:0]  rs_index
);

    // Classify the opcode/funct pair into a jump-unit path.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        path_index = PATH_SEQ;
        case (instr[31:26])
            OP_J:       path_index = PATH_J;
            OP_JAL:     path_index = PATH_JAL;
            OP_SPECIAL: if (instr[5:0] == FUNCT_JR) path_index = PATH_JR;
            default:    path_index = PATH_SEQ;
        endcase
    end

    assign jump     = (path_index != PATH_SEQ);
    assign addr     = instr[25:0];
    assign rs_index = instr[25:21];

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer owning the architectural PC and initiating jump-unit requests.
// Optional feature: define SEQ_TIMEOUT_EN to bound the EXEC wait to TIMEOUT_CYCLES
// cycles; on expiry the sequencer parks in ERROR with a sticky error flag.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fetch_req,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic [31:0]           pc,
    output logic [4:0]            rs_sel,
    input  logic [31:0]           rs_data,
    pc_sequencer_if.master        ju,
    output logic                  link_we,
    output logic [31:0]           link_data,
    output logic                  busy,
    output logic                  error
);

    state_t      state, state_nx;
    logic        idle_hold;
    logic        exec_first;
    logic        done_accept;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] reg_addr_q;
    logic [31:0] target_q;
    logic [3:0]  path_q;
    logic        jump_q;
    logic [25:0] addr_q;

    logic [3:0]  dec_path;
    logic        dec_jump;
    logic [25:0] dec_addr;
    logic [4:0]  dec_rs;

    jump_decoder u_dec (
        .instr      (instr_q),
        .path_index (dec_path),
        .jump       (dec_jump),
        .addr       (dec_addr),
        .rs_index   (dec_rs)
    );

    // A done in the first EXEC cycle may be left over from the previous request.
    assign done_accept = (state == S_EXEC) && !exec_first && ju.unit_done;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] exec_cnt;
    logic             timeout_hit;

    // exec_cnt holds the zero-based index of the current EXEC cycle.
    assign timeout_hit = (exec_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count EXEC cycles, restarting on every EXEC entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt <= '0;
        end else if (state == S_DECODE) begin
            exec_cnt <= '0;
        end else if (state == S_EXEC) begin
            exec_cnt <= exec_cnt + CNT_W'(1);
        end
    end
`endif

    // Next-state logic; an accepted done takes priority over a timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!idle_hold) state_nx = S_FETCH;
            S_FETCH:  if (instr_valid) state_nx = S_DECODE;
            S_DECODE: state_nx = dec_jump ? S_EXEC : S_UPDATE;
            S_EXEC: begin
                if (done_accept) begin
                    state_nx = S_UPDATE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nx = S_ERROR;
                end
`endif
            end
            S_UPDATE: state_nx = S_FETCH;
            S_ERROR:  state_nx = S_ERROR;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
        end
    end

    // Datapath: instruction latch, decoded request fields, target capture and PC commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_hold  <= 1'b1;
            exec_first <= 1'b0;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            path_q     <= PATH_SEQ;
            jump_q     <= 1'b0;
            addr_q     <= '0;
            reg_addr_q <= '0;
            target_q   <= '0;
        end else begin
            if (state == S_IDLE) idle_hold <= 1'b0;
            exec_first <= (state == S_DECODE);
            if ((state == S_FETCH) && instr_valid) instr_q <= instr;
            if (state == S_DECODE) begin
                path_q     <= dec_path;
                jump_q     <= dec_jump;
                addr_q     <= dec_addr;
                reg_addr_q <= rs_data;
            end
            if (done_accept) target_q <= ju.next_pc;
            if (state == S_UPDATE) pc_q <= jump_q ? target_q : pc_q + 32'd1;
        end
    end

    // Outputs decode straight from state so reset drops them asynchronously.
    assign fetch_req     = (state == S_FETCH);
    assign ju.unit_en    = (state == S_EXEC);
    assign ju.jump       = jump_q;
    assign ju.path_index = path_q;
    assign ju.addr       = addr_q;
    assign ju.reg_addr   = reg_addr_q;
    assign busy          = (state != S_IDLE) && (state != S_ERROR);
    assign pc            = pc_q;
    assign rs_sel        = dec_rs;
    assign link_we       = (state == S_UPDATE) && (path_q == PATH_JAL);
    assign link_data     = link_we ? pc_q + 32'd1 : 32'd0;

`ifdef SEQ_TIMEOUT_EN
    assign error = (state == S_ERROR);
`else
    assign error = 1'b0;
`endif

endmodule
